// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, one-entry instruction buffer, next-PC from pcsrc/pctarget.
// Latency: zero-latency memory gives one instruction every 3 cycles (REQ accept -> response -> HOLD consume).
// Backpressure: the held instruction stays put until instr_ready; the request address stays put until imem_req_ready.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   imem_req_valid/ready    fetch request handshake, imem_req_addr = current pc
//   imem_resp_valid/data    one-cycle response, accepted only while waiting for it
//   instr_valid/ready       downstream handshake for the buffered instruction
//   instr, instr_pc         buffered instruction word and its address
//   opcode, func3, func7    decode fields sliced from instr
//   pcsrc, pctarget         redirect outcome, sampled only on a consume cycle
//   misalign_err, halted    sticky flags raised by a redirect to a non-word-aligned target
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  input  logic        pcsrc,
  input  logic [31:0] pctarget,
  output logic        misalign_err,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_vld_q;
  logic        req_vld_q;
  logic        misalign_q;
  logic        halted_q;

  logic        consume_d;
  logic        target_bad_d;
  logic [31:0] pc_seq_d;

  // A consume is only meaningful while an instruction is actually held.
  assign consume_d    = (state_q == S_HOLD) && instr_vld_q && instr_ready;
  assign target_bad_d = (pctarget[1:0] != 2'b00);
  // Sequential successor; 32-bit add wraps 0xFFFF_FFFC to 0 naturally.
  assign pc_seq_d     = instr_pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= RESET_PC;
      instr_vld_q <= 1'b0;
      req_vld_q   <= 1'b0;
      misalign_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          // Coming out of reset the request valid is still low; raise it
          // one cycle later so it is never asserted while reset is applied.
          if (!req_vld_q) begin
            req_vld_q <= 1'b1;
          end else if (imem_req_ready) begin
            req_vld_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            instr_q     <= imem_resp_data;
            instr_pc_q  <= pc_q;
            instr_vld_q <= 1'b1;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (consume_d) begin
            instr_vld_q <= 1'b0;
            if (pcsrc && target_bad_d) begin
              misalign_q <= 1'b1;
              halted_q   <= 1'b1;
              state_q    <= S_HALT;
            end else begin
              pc_q      <= pcsrc ? pctarget : pc_seq_d;
              // Raise the next request right away to keep the 3-cycle cadence.
              req_vld_q <= 1'b1;
              state_q   <= S_REQ;
            end
          end
        end
        S_HALT: begin
          // Only reset leaves this state.
          req_vld_q   <= 1'b0;
          instr_vld_q <= 1'b0;
        end
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req_valid = req_vld_q;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = instr_vld_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign opcode         = instr_q[6:0];
  assign func3          = instr_q[14:12];
  assign func7          = instr_q[31:25];
  assign misalign_err   = misalign_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        pcsrc;
  logic [31:0] pctarget;
  logic        misalign_err;
  logic        halted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: address the next fetch must use.
  logic [31:0] exp_pc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .func3(func3), .func7(func7),
    .pcsrc(pcsrc), .pctarget(pctarget),
    .misalign_err(misalign_err), .halted(halted)
  );

  task automatic drive_idle();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    instr_ready     = 1'b0;
    pcsrc           = 1'b0;
    pctarget        = $urandom;
  endtask

  // Memory side: wait for a request, stall it, accept, answer after lat cycles (lat >= 1).
  task automatic serve_fetch(input int stall, input int lat, input logic [31:0] data,
                             output logic [31:0] addr, output bit stable, output bit tmo,
                             output int acc_cyc);
    int n;
    n = 0; tmo = 0; stable = 1; addr = '0; acc_cyc = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (imem_req_valid !== 1'b1) begin tmo = 1; return; end
    addr = imem_req_addr;
    for (int i = 0; i < stall; i++) begin
      imem_resp_valid = ($urandom % 2) == 1;   // spurious response while requesting
      @(negedge clk);
      if (imem_req_valid !== 1'b1 || imem_req_addr !== addr) stable = 0;
    end
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 1; i < lat; i++) @(negedge clk);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
  endtask

  task automatic consume(input logic s, input logic [31:0] t, output bit tmo);
    int n;
    n = 0; tmo = 0;
    while (instr_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (instr_valid !== 1'b1) begin tmo = 1; return; end
    instr_ready = 1'b1; pcsrc = s; pctarget = t;
    @(negedge clk);
    instr_ready = 1'b0; pcsrc = 1'b0; pctarget = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    checks++; if ({instr_valid, imem_req_valid, misalign_err, halted} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {instr_valid, imem_req_valid, misalign_err, halted}); end
    checks++; if (instr !== NOP_INSTR) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, NOP_INSTR); end
    checks++; if (instr_pc !== RESET_PC) begin errors++; $display("FAIL reset_instr_pc: got %h expected %h", instr_pc, RESET_PC); end
    checks++; if ({func7, func3, opcode} !== {7'b0, 3'b0, 7'b0010011}) begin
      errors++; $display("FAIL reset_fields: got %b %b %b expected 0000000 000 0010011", func7, func3, opcode); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_first_req: got v=%b a=%h expected v=1 a=%h", imem_req_valid, imem_req_addr, RESET_PC); end
    exp_pc = RESET_PC;
  endtask

  task automatic test_basic();
    logic [31:0] a; bit st, tmo; int c1, c2; logic [31:0] d2;
    serve_fetch(0, 1, 32'h0050_0093, a, st, tmo, c1);
    checks++; if (tmo || a !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h tmo=%0d expected 00000000", a, tmo); end
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093) begin
      errors++; $display("FAIL basic_instr: got v=%b %h expected v=1 00500093", instr_valid, instr); end
    checks++; if (opcode !== 7'b0010011 || func3 !== 3'b000 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL basic_fields: got op=%b f3=%b pc=%h expected op=0010011 f3=000 pc=0", opcode, func3, instr_pc); end
    consume(1'b0, 32'h0, tmo);
    d2 = $urandom;
    serve_fetch(0, 1, d2, a, st, tmo, c2);
    checks++; if (tmo || a !== 32'h4) begin errors++; $display("FAIL basic_next_addr: got %h expected 00000004", a); end
    checks++; if (c2 - c1 !== 3) begin errors++; $display("FAIL basic_throughput: got %0d cycles expected 3", c2 - c1); end
    checks++; if (instr !== d2 || instr_pc !== 32'h4) begin
      errors++; $display("FAIL basic_second: got %h@%h expected %h@00000004", instr, instr_pc, d2); end
    exp_pc = 32'h4;
  endtask

  task automatic test_backpressure();
    logic [31:0] si, sp, a, d; bit st, tmo; int c;
    si = instr; sp = instr_pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0 || instr !== si || instr_pc !== sp) begin
        errors++; $display("FAIL bp_hold: got v=%b rq=%b %h@%h expected v=1 rq=0 %h@%h", instr_valid, imem_req_valid, instr, instr_pc, si, sp); end
    end
    consume(1'b0, 32'h0, tmo);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_single_consume: got v=%b expected 0", instr_valid); end
    exp_pc = exp_pc + 32'd4;
    d = $urandom;
    serve_fetch(0, 1, d, a, st, tmo, c);
    checks++; if (tmo || a !== exp_pc) begin errors++; $display("FAIL bp_next_addr: got %h expected %h", a, exp_pc); end
  endtask

  task automatic test_branch();
    logic [31:0] a; bit st, tmo; int c;
    consume(1'b1, 32'h100, tmo);
    pcsrc = 1'b1; pctarget = 32'h202;   // must be ignored outside a consume
    serve_fetch(1, 2, $urandom, a, st, tmo, c);
    checks++; if (tmo || a !== 32'h100) begin errors++; $display("FAIL branch_addr: got %h expected 00000100", a); end
    repeat (2) @(negedge clk);
    checks++; if (halted !== 1'b0 || misalign_err !== 1'b0 || instr_pc !== 32'h100) begin
      errors++; $display("FAIL branch_noise: got h=%b e=%b pc=%h expected h=0 e=0 pc=00000100", halted, misalign_err, instr_pc); end
    consume(1'b0, 32'h0, tmo);
    serve_fetch(0, 1, $urandom, a, st, tmo, c);
    checks++; if (tmo || a !== 32'h104) begin errors++; $display("FAIL branch_seq_addr: got %h expected 00000104", a); end
    exp_pc = 32'h104;
  endtask

  task automatic test_random();
    logic [31:0] a, d, t, si; bit st, tmo, take; int c, h;
    for (int k = 0; k < 30; k++) begin
      take = ($urandom % 2) == 1;
      t = $urandom; t[1:0] = 2'b00;
      consume(take, t, tmo);
      exp_pc = take ? t : exp_pc + 32'd4;
      d = $urandom;
      serve_fetch($urandom_range(0, 3), $urandom_range(1, 4), d, a, st, tmo, c);
      checks++; if (tmo || a !== exp_pc || !st) begin
        errors++; $display("FAIL rand_req[%0d]: got %h stable=%0d tmo=%0d expected %h", k, a, st, tmo, exp_pc); end
      checks++; if (instr_valid !== 1'b1 || instr !== d || instr_pc !== exp_pc) begin
        errors++; $display("FAIL rand_buf[%0d]: got v=%b %h@%h expected v=1 %h@%h", k, instr_valid, instr, instr_pc, d, exp_pc); end
      checks++; if (opcode !== d[6:0] || func3 !== d[14:12] || func7 !== d[31:25]) begin
        errors++; $display("FAIL rand_fields[%0d]: got %h %h %h expected %h %h %h", k, opcode, func3, func7, d[6:0], d[14:12], d[31:25]); end
      si = instr;
      h = $urandom_range(0, 3);
      for (int i = 0; i < h; i++) begin
        pcsrc = 1'b1; pctarget = $urandom;
        @(negedge clk);
      end
      checks++; if (instr !== si || imem_req_valid !== 1'b0 || halted !== 1'b0) begin
        errors++; $display("FAIL rand_hold[%0d]: got %h rq=%b h=%b expected %h rq=0 h=0", k, instr, imem_req_valid, halted, si); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a; bit st, tmo; int c;
    consume(1'b1, 32'hFFFF_FFFC, tmo);
    serve_fetch(3, 4, $urandom, a, st, tmo, c);
    checks++; if (tmo || a !== 32'hFFFF_FFFC || !st) begin
      errors++; $display("FAIL wrap_stall_addr: got %h stable=%0d expected fffffffc stable=1", a, st); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_instr_pc: got v=%b %h expected v=1 fffffffc", instr_valid, instr_pc); end
    consume(1'b0, 32'h0, tmo);
    serve_fetch(0, 1, $urandom, a, st, tmo, c);
    checks++; if (tmo || a !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got %h expected 00000000", a); end
    exp_pc = 32'h0;
  endtask

  task automatic test_misalign();
    logic [31:0] a, d; bit st, tmo; int c, reqs;
    consume(1'b1, 32'h102, tmo);
    checks++; if ({misalign_err, halted, instr_valid, imem_req_valid} !== 4'b1100) begin
      errors++; $display("FAIL misalign_flags: got %b expected 1100", {misalign_err, halted, instr_valid, imem_req_valid}); end
    reqs = 0;
    instr_ready = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) reqs++;
    end
    instr_ready = 1'b0; imem_req_ready = 1'b0;
    checks++; if (reqs !== 0 || halted !== 1'b1 || misalign_err !== 1'b1) begin
      errors++; $display("FAIL misalign_halt: got handshakes=%0d h=%b e=%b expected 0 1 1", reqs, halted, misalign_err); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (misalign_err !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL misalign_reset: got e=%b h=%b expected 0 0", misalign_err, halted); end
    d = $urandom;
    serve_fetch(0, 1, d, a, st, tmo, c);
    checks++; if (tmo || a !== RESET_PC || instr !== d) begin
      errors++; $display("FAIL misalign_refetch: got %h instr=%h expected %h instr=%h", a, instr, RESET_PC, d); end
    exp_pc = RESET_PC;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a, d; bit st, tmo; int c, n;
    consume(1'b0, 32'h0, tmo);
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;           // DUT now waiting for the response
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;   // stale response
    @(negedge clk);
    imem_resp_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== NOP_INSTR) begin
      errors++; $display("FAIL stale_resp: got v=%b %h expected v=0 %h", instr_valid, instr, NOP_INSTR); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stale_valid: got %b expected 0", instr_valid); end
    d = $urandom;
    serve_fetch(1, 2, d, a, st, tmo, c);
    checks++; if (tmo || a !== RESET_PC || instr_valid !== 1'b1 || instr !== d) begin
      errors++; $display("FAIL mid_wait_refetch: got %h v=%b %h expected %h v=1 %h", a, instr_valid, instr, RESET_PC, d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_branch();
    test_random();
    test_wrap();
    test_misalign();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch front end that sources the opcode/func3/func7 fields the control decoder consumes, and applies the decoder's pcsrc/jump outcome to compute the next PC. It sits between a variable-latency instruction memory (request/response handshake) and the decode/execute stage (valid/ready handshake). There is one outstanding memory request at most, and a one-entry instruction holding buffer.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction buffer value after reset (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_resp_valid  input  1  response data valid (one cycle per request)
imem_resp_data  input  32  fetched instruction word
instr_valid  output  1  instruction buffer holds a valid instruction
instr_ready  input  1  downstream consumes instruction this cycle
instr  output  32  buffered instruction
instr_pc  output  32  PC of buffered instruction
opcode  output  7  instr[6:0]
func3  output  3  instr[14:12]
func7  output  7  instr[31:25]
pcsrc  input  1  taken branch/jump for the current instruction, from control
pctarget  input  32  target address when pcsrc=1
misalign_err  output  1  sticky; redirect target not word-aligned
halted  output  1  fetch stopped due to misalign_err

Behaviour:
- Reset (sync, active-high) has priority over all other inputs:
  - pc=RESET_PC, instr=NOP_INSTR, instr_pc=RESET_PC.
  - instr_valid=0, imem_req_valid=0, misalign_err=0, halted=0.
  - state=REQ on the next cycle.
- opcode/func3/func7 are combinational slices of the instr register; they are defined at all times, including NOP fields after reset.
- State machine (REQ, WAIT, HOLD, HALT):
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, go to WAIT. The address is held stable while valid and not ready.
  - WAIT: imem_req_valid=0. On imem_resp_valid, capture instr=imem_resp_data and instr_pc=pc, set instr_valid=1, and go to HOLD.
  - HOLD: instr_valid=1, instr/instr_pc held stable. On instr_valid & instr_ready (consume), go to REQ, clear instr_valid, and update pc:
    - pcsrc=1 and pctarget[1:0]==0: pc=pctarget.
    - pcsrc=0: pc=instr_pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
    - pcsrc=1 and pctarget[1:0]!=0: set misalign_err=1 and halted=1, pc unchanged, go to HALT.
  - HALT: all handshake outputs 0. Only reset exits this state.
- pcsrc/pctarget are sampled only on a consume cycle and ignored otherwise.
- imem_resp_valid in REQ, HOLD or HALT (spurious) is ignored; no state change.
- imem_req_ready in WAIT/HOLD/HALT is ignored.
- Minimum throughput: one instruction per 3 cycles with zero-latency memory (REQ accept → resp → HOLD consume).
- A response in the same cycle as request acceptance is not allowed by the protocol. Memory responds ≥1 cycle after acceptance.
- Reset asserted in WAIT discards the in-flight response. The memory is reset by the same signal.
- instr_valid never drops without a consume, except on reset.

Test Plan:
- Reset, then zero-latency memory returning 0x00500093 at 0x0, instr_ready=1 → request addr 0x0; instr_valid=1 with opcode=0010011, func3=000, instr_pc=0; next request addr 0x4.
- Backpressure: instr_ready=0 for 5 cycles in HOLD → instr and instr_pc stable, no new imem_req_valid. Then ready=1 → exactly one consume and a request at pc+4.
- Taken branch: consume with pcsrc=1, pctarget=0x100 → next imem_req_addr=0x100. pcsrc=1 outside a consume cycle → no effect.
- Misaligned target: pcsrc=1, pctarget=0x102 on consume → misalign_err=1 and halted=1 next cycle, no further requests; reset clears both and refetches RESET_PC.
- Wrap and stalls: pc=0xFFFF_FFFC, imem_req_ready low 3 cycles, response after 4 cycles → address held stable; after consume, next addr=0x0000_0000.
- Reset mid-WAIT, then a stale imem_resp_valid → ignored; instr_valid stays 0 until a fresh request to RESET_PC completes.
